// File: rtl/pole_mac.sv
// Pole half of an IIR biquad: y = sat24((x - P1*y1 - P2*y2) >>> SHIFT).
// Define IIR_POLE_ROUND_EN for round-half-up instead of floor in SAT.
module pole_mac #(
  parameter logic signed [16:0] P1    = -17'sd62259,
  parameter logic signed [16:0] P2    = 17'sd29655,
  parameter int                 SHIFT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [42:0] Xin,
  input  logic               in_valid,
  input  logic               clr,
  output logic signed [23:0] Yout,
  output logic               out_valid,
  output logic               busy,
  output logic               sat_flag,
  output logic               drop_flag
);

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    SAT
  } state_t;

  localparam logic signed [45:0] YMAX = 46'sd8388607;
  localparam logic signed [45:0] YMIN = -46'sd8388608;
`ifdef IIR_POLE_ROUND_EN
  localparam logic signed [45:0] HALF = 46'sd1 <<< (SHIFT - 1);
`endif

  state_t             state_q, state_d;
  logic signed [45:0] acc_q, acc_d;
  logic signed [23:0] y1_q, y1_d;
  logic signed [23:0] y2_q, y2_d;
  logic signed [23:0] yout_d;
  logic               ov_d;
  logic               sat_d;
  logic               drop_d;

  logic signed [16:0] coef;
  logic signed [23:0] opnd;
  logic signed [40:0] prod;
  logic signed [45:0] prod_ext;
  logic signed [45:0] shifted;
  logic signed [23:0] ysat;
  logic               clamp;

  // One shared multiplier; the operand pair follows the state
  always_comb begin
    coef = P1;
    opnd = y1_q;
    if (state_q == MUL2) begin
      coef = P2;
      opnd = y2_q;
    end
  end

  assign prod     = coef * opnd;
  assign prod_ext = {{5{prod[40]}}, prod};

`ifdef IIR_POLE_ROUND_EN
  assign shifted = (acc_q + HALF) >>> SHIFT;
`else
  assign shifted = acc_q >>> SHIFT;
`endif

  always_comb begin
    ysat  = shifted[23:0];
    clamp = 1'b0;
    if (shifted > YMAX) begin
      ysat  = YMAX[23:0];
      clamp = 1'b1;
    end else if (shifted < YMIN) begin
      ysat  = YMIN[23:0];
      clamp = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    yout_d  = Yout;
    ov_d    = 1'b0;
    sat_d   = sat_flag;
    drop_d  = drop_flag;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      y1_d    = '0;
      y2_d    = '0;
      yout_d  = '0;
      sat_d   = 1'b0;
      drop_d  = 1'b0;
    end else begin
      if (in_valid && state_q != IDLE)
        drop_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = {{3{Xin[42]}}, Xin};
            state_d = MUL1;
          end
        end
        MUL1: begin
          acc_d   = acc_q - prod_ext;
          state_d = MUL2;
        end
        MUL2: begin
          acc_d   = acc_q - prod_ext;
          state_d = SAT;
        end
        SAT: begin
          yout_d  = ysat;
          y1_d    = ysat;
          y2_d    = y1_q;
          ov_d    = 1'b1;
          state_d = IDLE;
          if (clamp)
            sat_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      Yout      <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      Yout      <= yout_d;
      out_valid <= ov_d;
      sat_flag  <= sat_d;
      drop_flag <= drop_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pole_mac.sv
// Directed bench for pole_mac: vector table plus reset/drop/clear sequences.
// Expected values follow IIR_POLE_ROUND_EN when defined.
module tb_pole_mac;

`ifdef IIR_POLE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [42:0] Xin = '0;
  logic               in_valid = 1'b0;
  logic               clr = 1'b0;
  logic signed [23:0] Yout;
  logic               out_valid;
  logic               busy;
  logic               sat_flag;
  logic               drop_flag;

  int checks = 0;
  int errors = 0;

  pole_mac dut (
    .clk       (clk),
    .rst       (rst),
    .Xin       (Xin),
    .in_valid  (in_valid),
    .clr       (clr),
    .Yout      (Yout),
    .out_valid (out_valid),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .drop_flag (drop_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 do_clr;
    logic signed [42:0] xin;
    logic signed [23:0] y;
    bit                 sat;
  } vec_t;

  vec_t tv[13];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic wait_ov(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_sample(input logic signed [42:0] x,
                            output logic signed [23:0] y,
                            output int lat, output bit one_shot);
    @(posedge clk); #1;
    in_valid = 1'b1;
    Xin = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ov(10, lat);
    y = Yout;
    @(posedge clk); #1;
    one_shot = !out_valid;
  endtask

  logic signed [23:0] y;
  int lat, cnt, n;
  bit one_shot, busy_at;

  initial begin
    tv[0]  = '{1, 43'sd32768000, 24'sd1000, 0};
    tv[1]  = '{0, 43'sd0, RND ? 24'sd1900 : 24'sd1899, 0};
    tv[2]  = '{0, 43'sd0, RND ? 24'sd2705 : 24'sd2703, 0};
    tv[3]  = '{1, 43'sd1 <<< 41, 24'sd8388607, 1};
    tv[4]  = '{0, 43'(-64'sd62259 * 64'sd8388607), 24'sd0, 1};
    tv[5]  = '{0, 43'sd0, RND ? -24'sd7591679 : -24'sd7591680, 1};
    tv[6]  = '{1, -(43'sd1 <<< 41), -24'sd8388608, 1};
    tv[7]  = '{1, -43'sd32768000, -24'sd1000, 0};
    tv[8]  = '{1, -43'sd32768001, RND ? -24'sd1000 : -24'sd1001, 0};
    tv[9]  = '{1, 43'(64'sd32768 * 64'sd8388607 + 64'sd32767), 24'sd8388607, RND};
    tv[10] = '{1, 43'(64'sd32768 * 64'sd8388608), 24'sd8388607, 1};
    tv[11] = '{1, 43'(-64'sd32768 * 64'sd8388608 - 64'sd1), -24'sd8388608, !RND};
    tv[12] = '{1, 43'sd16384, RND ? 24'sd1 : 24'sd0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_yout", Yout, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_drop", drop_flag, 0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (tv[i].do_clr) do_clr();
      run_sample(tv[i].xin, y, lat, one_shot);
      check($sformatf("v%0d_yout", i), y, tv[i].y);
      check($sformatf("v%0d_lat", i), lat, 3);
      check($sformatf("v%0d_sat", i), sat_flag, tv[i].sat);
      check($sformatf("v%0d_oneshot", i), one_shot, 1);
      check($sformatf("v%0d_drop", i), drop_flag, 0);
    end

    // Reset in MUL2 with nonzero history and flags
    do_clr();
    run_sample(43'sd1 <<< 41, y, lat, one_shot);
    @(posedge clk); #1 in_valid = 1'b1; Xin = '0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("arst_yout", Yout, 0);
    check("arst_ov", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sat", sat_flag, 0);
    check("arst_drop", drop_flag, 0);
    @(posedge clk); #1 rst = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("arst_no_ov", cnt, 0);
    run_sample(43'sd32768000, y, lat, one_shot);
    check("arst_next", y, 1000);

    // Second in_valid at E1 is dropped
    do_clr();
    @(posedge clk); #1 in_valid = 1'b1; Xin = 43'sd32768000;
    @(posedge clk); #1 Xin = '0;
    @(posedge clk); #1 in_valid = 1'b0;
    cnt = 0;
    busy_at = 1'b1;
    y = '0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        y = Yout;
        busy_at = busy;
      end
    end
    check("drop_cnt", cnt, 1);
    check("drop_yout", y, 1000);
    check("drop_flag", drop_flag, 1);
    check("drop_busy", busy_at, 0);

    // Back-to-back at E4 is accepted
    do_clr();
    @(posedge clk); #1 in_valid = 1'b1; Xin = 43'sd32768000;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(10, n);
    check("b2b_first", Yout, 1000);
    in_valid = 1'b1;
    Xin = '0;
    @(posedge clk); #1 in_valid = 1'b0;
    check("b2b_busy", busy, 1);
    wait_ov(10, n);
    check("b2b_lat", n, 3);
    check("b2b_yout", Yout, RND ? 1900 : 1899);
    check("b2b_drop", drop_flag, 0);

    // clr with in_valid during MUL1
    do_clr();
    run_sample(43'sd1 <<< 41, y, lat, one_shot);
    @(posedge clk); #1 in_valid = 1'b1; Xin = '0;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_ov(10, n);
    @(posedge clk); #1 in_valid = 1'b1; Xin = '0;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;
    check("clr_yout", Yout, 0);
    check("clr_ov", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_sat", sat_flag, 0);
    check("clr_drop", drop_flag, 0);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("clr_no_ov", cnt, 0);
    run_sample(43'sd0, y, lat, one_shot);
    check("clr_next", y, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
